bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Parametrised mm:ss BCD countdown timer with loadable preset, run/pause control, internal one-second prescaler and an LED alarm that can blink. It is the next generation of the lab countdown block. It feeds four BCD digits to the existing seven-segment scan driver and drives the board LED bank. Clock rate, LED width, alarm blink rate and power-on preset are parameters.

## Interface
- CLK_HZ, 100_000_000: clk cycles per count tick (one second); must be ≥ 2.
- LED_W, 16: LED bank width.
- BLINK_TICKS, 0: count ticks per alarm half-period; 0 = steady alarm.
- RST_MIN, 8'h00: BCD minutes loaded at reset.
- RST_SEC, 8'h30: BCD seconds loaded at reset.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  one-cycle strobe: capture preset_min/preset_sec, enter IDLE
- run  in  1  level: 1 = count, 0 = pause
- preset_min  in  8  BCD minutes {tens, ones}
- preset_sec  in  8  BCD seconds {tens, ones}
- dig3, dig2, dig1, dig0  out  4 each  min tens, min ones, sec tens, sec ones
- done  out  1  high while in DONE
- led  out  LED_W  alarm pattern
- state_o  out  2  current state encoding

## Operation
- States: IDLE (00), RUN (01), PAUSE (10), DONE (11).
- Reset: digits = RST_MIN/RST_SEC, state IDLE, prescaler 0, done 0, led all 0, blink phase 0.
- Preset sanitising on load: any digit > 9 becomes 9; sec tens > 5 becomes 5. Applies to RST_* as well.
- IDLE: run=1 → RUN, or → DONE if digits are 00:00.
- RUN: run=0 → PAUSE; prescaler increments each cycle. At CLK_HZ-1 it wraps to 0 and issues a tick.
- Tick decrement, BCD borrow chain:
  - sec ones 0→9 with borrow.
  - sec tens 0→5 with borrow.
  - min ones 0→9 with borrow.
  - min tens decrements.
- The tick that produces 00:00 also moves to DONE in the same update.
- PAUSE: prescaler holds its value, no ticks; run=1 → RUN and counting resumes from the held prescaler value.
- DONE: digits hold 00:00; done=1.
  - BLINK_TICKS=0: led all 1.
  - Otherwise led toggles between all 1 and all 0 every BLINK_TICKS ticks, starting all 1. The prescaler keeps running for the blink.
  - DONE is left only by load or reset.
- load has priority over everything except reset:
  - From any state → IDLE.
  - Prescaler cleared; led cleared.
  - New digits visible the cycle after the strobe.
- Outside DONE, led = 0 and done = 0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- load at edge N: digits, state IDLE and cleared prescaler are visible after edge N.
- run rising into IDLE at edge N: state RUN after N.
  - First tick occurs CLK_HZ cycles later.
  - Digits update on the edge that samples prescaler = CLK_HZ-1.
- done and led rise on the same edge that shows 00:00.
- Simultaneous load and tick: load wins; the tick is discarded.
- Simultaneous run=0 and tick in RUN: the tick is applied and state becomes PAUSE on that edge.
- rst_n assertion mid-count returns to the reset values immediately, asynchronously.

## Structure
- Shared package timer_pkg:
  - state typedef with the four encodings above.
  - BCD_W = 4.
  - Digit maxima 9 and 5 as named constants.
- Sub-module tick_prescaler, parameter CLK_HZ, ports:
  - clk, rst_n
  - clr, en
  - tick: one-cycle pulse, high when count = CLK_HZ-1 and en=1

## Test plan
- Parameters CLK_HZ=4, BLINK_TICKS=0; reset, run=1 → 00:30 → 00:29 after 4 cycles. Reaches 00:00 at tick 30 with done=1 and led=16'hFFFF the same cycle.
- Borrow chain: load 10:00 → after one tick 09:59; load 01:00 → 00:59.
- Sanitise: load preset_min=8'hA7, preset_sec=8'h9C → digits 9,7,5,9.
- Pause: run=0 at prescaler=2 → digits frozen for 20 cycles. run=1 → next tick 2 cycles later.
- Blink: BLINK_TICKS=2, count to 00:00 → led FFFF for 2 ticks, 0000 for 2 ticks, repeating. load 00:05 → IDLE, led=0, done=0.
- Corner cases:
  - load 00:00 then run=1 → DONE one cycle later.
  - load coinciding with tick → preset digits, no decrement.
  - rst_n pulse mid-RUN → 00:30, IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the mm:ss BCD countdown timer.
//   state_e     : IDLE/RUN/PAUSE/DONE encodings seen on state_o
//   bcd_time_t  : four BCD digits {min tens, min ones, sec tens, sec ones}
//   sanitise    : clamps a raw BCD preset into a legal mm:ss value
//   bcd_decrement / bcd_is_zero : one-second borrow chain and terminal test
package timer_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  // Clamp one BCD digit to an upper limit.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                   input logic [BCD_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Turn raw preset bytes into a legal mm:ss value (digits <= 9, sec tens <= 5).
  function automatic bcd_time_t sanitise(input logic [7:0] mins, input logic [7:0] secs);
    bcd_time_t t;
    t.min_tens = clamp_digit(mins[7:4], DIGIT_MAX);
    t.min_ones = clamp_digit(mins[3:0], DIGIT_MAX);
    t.sec_tens = clamp_digit(secs[7:4], SEC_TENS_MAX);
    t.sec_ones = clamp_digit(secs[3:0], DIGIT_MAX);
    return t;
  endfunction

  function automatic logic bcd_is_zero(input bcd_time_t t);
    return (t == '0);
  endfunction

  // Subtract one second with BCD borrow through all four digits.
  function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != '0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = DIGIT_MAX;
      if (t.sec_tens != '0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = SEC_TENS_MAX;
        if (t.min_ones != '0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          r.min_ones = DIGIT_MAX;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts clk cycles while enabled and pulses tick on the
// last cycle of each CLK_HZ-cycle period.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count enable; count holds while low
//   tick       : high when count == CLK_HZ-1 and en == 1
module tick_prescaler #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick decode and next count.
  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer with loadable preset, run/pause, one-second
// prescaler and an optionally blinking LED alarm.
//   clk, rst_n             : clock, async active-low reset
//   load                   : one-cycle strobe, capture preset and go IDLE
//   run                    : level, 1 = count, 0 = pause
//   preset_min/preset_sec  : BCD preset {tens, ones}
//   dig3..dig0             : min tens, min ones, sec tens, sec ones
//   done                   : high while in DONE
//   led                    : alarm pattern (steady or blinking)
//   state_o                : current state encoding
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned LED_W       = 16,
  parameter int unsigned BLINK_TICKS = 0,
  parameter logic [7:0]  RST_MIN     = 8'h00,
  parameter logic [7:0]  RST_SEC     = 8'h30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [7:0]       preset_min,
  input  logic [7:0]       preset_sec,
  output logic [BCD_W-1:0] dig3,
  output logic [BCD_W-1:0] dig2,
  output logic [BCD_W-1:0] dig1,
  output logic [BCD_W-1:0] dig0,
  output logic             done,
  output logic [LED_W-1:0] led,
  output logic [1:0]       state_o
);

  localparam bcd_time_t RST_TIME = sanitise(RST_MIN, RST_SEC);
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic BLINK_EN = (BLINK_TICKS != 0);

  state_e               state_q, state_d;
  bcd_time_t            time_q, time_d;
  logic                 done_q, done_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;

  logic                 tick;
  logic                 presc_en;
  logic                 enter_done;
  bcd_time_t            time_dec;

  // Prescaler runs while counting and while the alarm may need to blink.
  assign presc_en = (state_q == ST_RUN) || (state_q == ST_DONE);

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (presc_en),
    .tick  (tick)
  );

  assign time_dec = bcd_decrement(time_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    done_d      = done_q;
    led_d       = led_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    enter_done  = 1'b0;

    if (load) begin
      // Load overrides any tick on this edge.
      time_d      = sanitise(preset_min, preset_sec);
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      led_d       = '0;
      blink_cnt_d = '0;
      blink_on_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            if (bcd_is_zero(time_q)) begin
              enter_done = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // A tick coinciding with run=0 is still applied.
          if (tick) begin
            time_d = time_dec;
            if (bcd_is_zero(time_dec)) begin
              enter_done = 1'b1;
            end else if (!run) begin
              state_d = ST_PAUSE;
            end
          end else if (!run) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (run) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (BLINK_EN && tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              blink_on_d  = !blink_on_q;
              led_d       = {LED_W{!blink_on_q}};
            end else begin
              blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Alarm starts lit on the same edge that shows 00:00.
      if (enter_done) begin
        state_d     = ST_DONE;
        done_d      = 1'b1;
        led_d       = '1;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      time_q      <= RST_TIME;
      done_q      <= 1'b0;
      led_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      done_q      <= done_d;
      led_q       <= led_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign dig3    = time_q.min_tens;
  assign dig2    = time_q.min_ones;
  assign dig1    = time_q.sec_tens;
  assign dig0    = time_q.sec_ones;
  assign done    = done_q;
  assign led     = led_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (blinking and steady alarm)
// share stimulus and are compared every cycle against a seconds-based model.
module tb_bcd_countdown_timer;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned LED_W  = 16;
  localparam int unsigned BLINK  = 2;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic       run;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;

  logic [3:0]       a3, a2, a1, a0, z3, z2, z1, z0;
  logic             done_a, done_z;
  logic [LED_W-1:0] led_a, led_z;
  logic [1:0]       st_a, st_z;

  bcd_countdown_timer #(
    .CLK_HZ(CLK_HZ), .LED_W(LED_W), .BLINK_TICKS(BLINK), .RST_MIN(8'h00), .RST_SEC(8'h30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .run(run),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .dig3(a3), .dig2(a2), .dig1(a1), .dig0(a0),
    .done(done_a), .led(led_a), .state_o(st_a)
  );

  bcd_countdown_timer #(
    .CLK_HZ(CLK_HZ), .LED_W(LED_W), .BLINK_TICKS(0), .RST_MIN(8'h00), .RST_SEC(8'h30)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .run(run),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .dig3(z3), .dig2(z2), .dig1(z1), .dig0(z0),
    .done(done_z), .led(led_z), .state_o(st_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model: remaining time in whole seconds, state 0..3, prescaler count,
  // and number of ticks seen since DONE was entered.
  int m_state, m_total, m_presc, m_dticks;
  bit m_tick;

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int to_total(input logic [7:0] mi, input logic [7:0] se);
    int mt, mo, st, so;
    mt = clampi(int'(mi[7:4]), 9);
    mo = clampi(int'(mi[3:0]), 9);
    st = clampi(int'(se[7:4]), 5);
    so = clampi(int'(se[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] exp_digits(input int total);
    int m, s;
    m = total / 60;
    s = total % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] exp_led(input int blink_ticks);
    if (m_state != 3) return 16'h0000;
    if (blink_ticks == 0) return 16'hFFFF;
    return (((m_dticks / blink_ticks) % 2) == 0) ? 16'hFFFF : 16'h0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state  = 0;
      m_total  = to_total(8'h00, 8'h30);
      m_presc  = 0;
      m_dticks = 0;
    end else begin
      m_tick = (m_state == 1 || m_state == 3) && (m_presc == CLK_HZ - 1);
      if (load) begin
        m_total  = to_total(preset_min, preset_sec);
        m_state  = 0;
        m_presc  = 0;
        m_dticks = 0;
      end else begin
        if (m_state == 1 || m_state == 3) m_presc = (m_presc + 1) % CLK_HZ;
        case (m_state)
          0: if (run) begin
               m_state  = (m_total == 0) ? 3 : 1;
               m_dticks = 0;
             end
          1: begin
               if (m_tick) m_total = m_total - 1;
               if (m_tick && m_total == 0) begin
                 m_state  = 3;
                 m_dticks = 0;
               end else if (!run) begin
                 m_state = 2;
               end
             end
          2: if (run) m_state = 1;
          default: if (m_tick) m_dticks = m_dticks + 1;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("digits", 32'({a3, a2, a1, a0}), 32'(exp_digits(m_total)));
      check("state", 32'(st_a), 32'(m_state));
      check("done", 32'(done_a), 32'(m_state == 3));
      check("led_blink", 32'(led_a), 32'(exp_led(BLINK)));
      check("digits0", 32'({z3, z2, z1, z0}), 32'(exp_digits(m_total)));
      check("state0", 32'(st_z), 32'(m_state));
      check("done0", 32'(done_z), 32'(m_state == 3));
      check("led_steady", 32'(led_z), 32'(exp_led(0)));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] mi, input logic [7:0] se);
    load = 1'b1;
    preset_min = mi;
    preset_sec = se;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_model(input int st, input int pv, input string name);
    int n;
    n = 0;
    while (!(m_state == st && m_presc == pv) && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 40) begin
      n_err++;
      $display("FAIL %s: wait for state %0d prescaler %0d timed out", name, st, pv);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    load = 1'b0;
    run = 1'b0;
    preset_min = 8'h00;
    preset_sec = 8'h00;
    #1 rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset values and first tick latency.
    check("lit_reset_digits", 32'({a3, a2, a1, a0}), 32'h0030);
    check("lit_reset_state", 32'(st_a), 32'd0);
    run = 1'b1;
    cycles(4);
    check("lit_pre_tick", 32'({a3, a2, a1, a0}), 32'h0030);
    cycles(1);
    check("lit_first_tick", 32'({a3, a2, a1, a0}), 32'h0029);
    cycles(116);
    check("lit_zero", 32'({a3, a2, a1, a0}), 32'h0000);
    check("lit_done", 32'(done_a), 32'd1);
    check("lit_led_on", 32'(led_a), 32'hFFFF);
    check("lit_led0_on", 32'(led_z), 32'hFFFF);
    cycles(8);
    check("lit_blink_off", 32'(led_a), 32'h0000);
    check("lit_steady_on", 32'(led_z), 32'hFFFF);
    cycles(8);
    check("lit_blink_on", 32'(led_a), 32'hFFFF);
    cycles(13);

    // Load leaves DONE and clears the alarm.
    do_load(8'h00, 8'h05);
    check("lit_load_state", 32'(st_a), 32'd0);
    check("lit_load_led", 32'(led_a), 32'h0000);
    check("lit_load_done", 32'(done_a), 32'd0);
    check("lit_load_digits", 32'({a3, a2, a1, a0}), 32'h0005);
    cycles(2);

    // Borrow chain.
    do_load(8'h10, 8'h00);
    check("lit_load_1000", 32'({a3, a2, a1, a0}), 32'h1000);
    cycles(5);
    check("lit_borrow_0959", 32'({a3, a2, a1, a0}), 32'h0959);
    do_load(8'h01, 8'h00);
    cycles(5);
    check("lit_borrow_0059", 32'({a3, a2, a1, a0}), 32'h0059);

    // Sanitising, then pause with prescaler at 2.
    do_load(8'hA7, 8'h9C);
    check("lit_sanitise", 32'({a3, a2, a1, a0}), 32'h9759);
    cycles(3);
    run = 1'b0;
    cycles(21);
    check("lit_paused_state", 32'(st_a), 32'd2);
    check("lit_paused_digits", 32'({a3, a2, a1, a0}), 32'h9759);
    run = 1'b1;
    cycles(1);
    check("lit_resume_state", 32'(st_a), 32'd1);
    check("lit_resume_hold", 32'({a3, a2, a1, a0}), 32'h9759);
    cycles(1);
    check("lit_resume_tick", 32'({a3, a2, a1, a0}), 32'h9758);

    // 00:00 preset goes straight to DONE.
    run = 1'b0;
    do_load(8'h00, 8'h00);
    check("lit_zero_idle", 32'(st_a), 32'd0);
    run = 1'b1;
    cycles(1);
    check("lit_zero_done_state", 32'(st_a), 32'd3);
    check("lit_zero_done", 32'(done_a), 32'd1);

    // Load on the tick edge: preset wins, no decrement.
    run = 1'b0;
    do_load(8'h00, 8'h20);
    run = 1'b1;
    cycles(2);
    wait_model(1, CLK_HZ - 1, "tick_align");
    do_load(8'h12, 8'h34);
    check("lit_load_vs_tick", 32'({a3, a2, a1, a0}), 32'h1234);
    check("lit_load_vs_tick_st", 32'(st_a), 32'd0);

    // Randomised load/run traffic with short presets so DONE is visited.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 14) == 0) run = ~run;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) do_load(8'h00, {4'h0, 4'($urandom_range(0, 3))});
        else do_load(8'($urandom), 8'($urandom));
      end else begin
        cycles(1);
      end
    end

    // Asynchronous reset in the middle of a count.
    run = 1'b1;
    do_load(8'h05, 8'h00);
    cycles(10);
    check("lit_mid_run", 32'(st_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_digits", 32'({a3, a2, a1, a0}), 32'h0030);
    check("lit_async_state", 32'(st_a), 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
